clk_en_gen: RTL and testbench
=============================

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024, meaning on-chip oscillator cycles held in reset after reset release.
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of divide register and counter.
REQ-003 SHALL have clk  input  1  free-running on-chip oscillator clock; all logic on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have en  input  1  tick generation enable.
REQ-006 SHALL have div_val  input  DIV_W  requested period minus one.
REQ-007 SHALL have div_load  input  1  one-cycle strobe capturing div_val.
REQ-008 SHALL have sys_rst_n  output  1  downstream reset, asserted asynchronously, released synchronously.
REQ-009 SHALL have ready  output  1  high once hold period is complete.
REQ-010 SHALL have tick  output  1  one-cycle clock-enable pulse.
REQ-011 SHALL have div_clk  output  1  registered square wave toggling on each tick.

Function
REQ-012 SHALL pass rst_n through a two-flop synchronizer; both flops clear asynchronously when rst_n=0, and shift in 1 when rst_n=1.
REQ-013 SHALL use three states: HOLD, IDLE, RUN.
REQ-014 HOLD: SHALL increment hold counter once per cycle while the synchronizer output is 1; on the cycle the count reaches HOLD_CYCLES-1, SHALL go to IDLE.
REQ-015 SHALL drive sys_rst_n=1 and ready=1 starting the first cycle in IDLE; 0 in HOLD.
REQ-016 IDLE to RUN when en=1; RUN to IDLE when en=0; the transition takes effect on the next edge.
REQ-017 RUN: SHALL count down from the active divide value; tick=1 for exactly one cycle when the counter is 0, then reload the active divide value on that same edge.
REQ-018 Tick period SHALL be active_div+1 cycles; active_div=0 gives tick=1 every RUN cycle.
REQ-019 First tick after entering RUN SHALL occur active_div+1 cycles after the en-sampling edge.
REQ-020 IDLE: tick=0, counter held at active_div, div_clk holds its value.
REQ-021 div_load: SHALL capture div_val into a shadow register. In IDLE/HOLD, SHALL copy the shadow value to active_div immediately. In RUN, SHALL copy it at the next reload (tick cycle), so that no period is truncated.
REQ-022 div_load coincident with the tick cycle: the new value SHALL govern the immediately following period.
REQ-023 Repeated div_load before the next tick: the last captured value wins.
REQ-024 div_load in HOLD SHALL be accepted; ticks SHALL never assert in HOLD.
REQ-025 div_clk SHALL toggle on the edge where tick=1, giving period 2*(active_div+1).
REQ-026 Counter arithmetic SHALL be unsigned DIV_W-bit; all-ones divide value SHALL be legal, with no overflow wrap.

Reset
REQ-027 rst_n=0 at any time, including mid-period, SHALL asynchronously force the following: state=HOLD, sys_rst_n=0, ready=0, tick=0, div_clk=0, counter=0, hold counter=0, and shadow/active_div=0.
REQ-028 After rst_n rises, sys_rst_n SHALL rise exactly 2+HOLD_CYCLES edges later; the release SHALL be synchronous to clk.
REQ-029 A rst_n glitch shorter than one cycle SHALL still restart the full hold sequence.

Verification
REQ-030 With HOLD_CYCLES=8, release rst_n at edge 0 -> sys_rst_n/ready rise after edge 10, not before; tick stays 0 throughout.
REQ-031 With div_val=4 loaded in IDLE and then en=1 -> tick at every 5th cycle, div_clk period 10 cycles, over 20 periods.
REQ-032 With div=0 and en=1 -> tick high every cycle; div_clk toggles every cycle.
REQ-033 In RUN with div=9, load div_val=2 mid-period -> current period completes at 10 cycles, subsequent periods are 3 cycles; a load coincident with the tick also gives 3 next.
REQ-034 Drop en mid-period -> tick stops and div_clk freezes; re-raise en -> first tick after active_div+1 cycles.
REQ-035 Assert rst_n=0 mid-RUN for half a cycle -> all outputs 0 immediately; full hold sequence repeats; active_div reads 0 afterwards.

Source files
------------

// File: rtl/clk_en_gen.sv
// ---------------------------------------------------------------------------
// clk_en_gen
//
// Reset sequencer plus programmable clock-enable generator, both running on
// a free-running on-chip oscillator.
//
// After rst_n is released, the block holds the downstream reset for
// 2 + HOLD_CYCLES clock edges:
//   - 2 edges go to the reset synchronizer.
//   - HOLD_CYCLES edges go to the hold counter.
// It then releases sys_rst_n and raises ready. From then on, en starts and
// stops a divider that emits a one-cycle tick every (active_div + 1) cycles.
// div_clk is a square wave that toggles on each tick.
//
// Parameters
//   HOLD_CYCLES : oscillator cycles held in reset after the synchronizer
//   DIV_W       : width of the divide value and the period counter
//
// Ports
//   clk       in   oscillator clock; all logic uses its rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   tick generation enable
//   div_val   in   requested period minus one
//   div_load  in   one-cycle strobe that captures div_val
//   sys_rst_n out  downstream reset; asserted asynchronously, released
//                  synchronously
//   ready     out  high once the hold period is complete
//   tick      out  one-cycle clock-enable pulse
//   div_clk   out  registered square wave, toggles on each tick
//
// Outputs are registered. tick is high in the cycle where the period counter
// is 0, so tick and the counter stay aligned without a combinational path.
// ---------------------------------------------------------------------------
module clk_en_gen #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             tick,
  output logic             div_clk
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  // Reset synchronizer
  logic sync1_q;
  logic sync2_q;

  // Sequencer / divider state
  state_e            state_q,     state_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [DIV_W-1:0]  cnt_q,       cnt_d;
  logic [DIV_W-1:0]  active_q,    active_d;
  logic [DIV_W-1:0]  shadow_q,    shadow_d;
  logic              pending_q,   pending_d;

  // Registered outputs
  logic              tick_q,      tick_d;
  logic              div_clk_q,   div_clk_d;
  logic              ready_q,     ready_d;
  logic              sys_rst_n_q, sys_rst_n_d;

  // Value a reload takes.
  // A strobe on the reload cycle itself governs the next period. Otherwise a
  // pending shadow value is used, and failing that the current value.
  logic [DIV_W-1:0]  reload_val_s;

  // Two-flop synchronizer: clears asynchronously, releases on clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  // Select the divide value used at the next reload point
  always_comb begin
    reload_val_s = active_q;
    if (div_load) begin
      reload_val_s = div_val;
    end else if (pending_q) begin
      reload_val_s = shadow_q;
    end else begin
      reload_val_s = active_q;
    end
  end

  // Next-state logic for the sequencer FSM, divider and outputs
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;

    // The shadow register always tracks the most recent strobe
    if (div_load) begin
      shadow_d = div_val;
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      ST_HOLD: begin
        // No period is in flight, so a load applies at once
        if (div_load) begin
          active_d = div_val;
        end else begin
          active_d = active_q;
        end
        pending_d = 1'b0;
        // Count only once the synchronized reset has been released
        if (sync2_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end else begin
          hold_cnt_d = HOLD_ZERO;
        end
        cnt_d = active_d;
      end

      ST_IDLE: begin
        if (div_load) begin
          active_d = div_val;
        end else begin
          active_d = active_q;
        end
        pending_d = 1'b0;
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
        // Preload so the first tick lands active_div+1 cycles after en
        cnt_d = active_d;
      end

      ST_RUN: begin
        if (!en) begin
          // Leaving RUN: settle any pending value and park the counter
          state_d   = ST_IDLE;
          active_d  = reload_val_s;
          cnt_d     = reload_val_s;
          pending_d = 1'b0;
        end else if (cnt_q == DIV_ZERO) begin
          // Tick cycle: reload, picking up any pending value
          active_d  = reload_val_s;
          cnt_d     = reload_val_s;
          pending_d = 1'b0;
        end else begin
          // Mid-period: defer loads so the current period is not truncated
          cnt_d = cnt_q - DIV_ONE;
          if (div_load) begin
            pending_d = 1'b1;
          end else begin
            pending_d = pending_q;
          end
        end
      end

      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_ZERO;
        cnt_d      = DIV_ZERO;
        active_d   = DIV_ZERO;
        pending_d  = 1'b0;
      end
    endcase

    // tick is high exactly while the counter sits at 0 in RUN
    tick_d      = (state_d == ST_RUN) && (cnt_d == DIV_ZERO);
    div_clk_d   = tick_q ? ~div_clk_q : div_clk_q;
    ready_d     = (state_d != ST_HOLD);
    sys_rst_n_d = (state_d != ST_HOLD);
  end

  // Sequencer FSM, divider and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_ZERO;
      cnt_q       <= DIV_ZERO;
      active_q    <= DIV_ZERO;
      shadow_q    <= DIV_ZERO;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      div_clk_q   <= 1'b0;
      ready_q     <= 1'b0;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      div_clk_q   <= div_clk_d;
      ready_q     <= ready_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign tick      = tick_q;
  assign div_clk   = div_clk_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_en_gen
//
// Directed bench for clk_en_gen with HOLD_CYCLES=8 and DIV_W=8.
//
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
//
// The expected tick schedule is kept as an absolute cycle number:
//   - When en is raised in cycle c with period P, the first tick is seen
//     after edge c+P.
//   - Each later tick follows the previous one by the period in force at
//     that tick.
// ---------------------------------------------------------------------------
module tb_clk_en_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       sys_rst_n;
  logic       ready;
  logic       tick;
  logic       div_clk;

  int errors = 0;
  int checks = 0;

  // Reference model of the tick schedule
  int cyc         = 0;
  int next_tick   = 0;
  int cur_period  = 1;
  int new_period  = 1;
  bit running     = 1'b0;
  bit prev_tick   = 1'b0;
  bit exp_dc      = 1'b0;

  clk_en_gen #(
    .HOLD_CYCLES(8),
    .DIV_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .tick     (tick),
    .div_clk  (div_clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Ten edges after rst_n release: ready/sys_rst_n rise only after the 10th
  task automatic hold_seq(input bit load_in_hold);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("tick_in_hold", tick, 1'b0);
      chk("ready_hold", ready, (i == 10));
      chk("sys_rst_n_hold", sys_rst_n, (i == 10));
      if (load_in_hold && (i == 3)) begin
        div_val  = 8'd4;
        div_load = 1'b1;
      end else begin
        div_load = 1'b0;
      end
    end
    chk("div_clk_after_hold", div_clk, 1'b0);
  endtask

  // Advance n cycles, checking tick and div_clk against the schedule
  task automatic run(input int n);
    bit t;
    for (int i = 0; i < n; i++) begin
      step();
      exp_dc = exp_dc ^ prev_tick;
      chk("div_clk", div_clk, exp_dc);
      t = running && (cyc == next_tick);
      if (t) begin
        cur_period = new_period;
        next_tick  = cyc + cur_period;
      end
      chk("tick", tick, t);
      prev_tick = t;
    end
  endtask

  task automatic run_until_tick();
    for (int i = 0; i < 300; i++) begin
      run(1);
      if (prev_tick) break;
    end
  endtask

  task automatic start_run(input int period);
    cur_period = period;
    new_period = period;
    en         = 1'b1;
    running    = 1'b1;
    next_tick  = cyc + period;
  endtask

  task automatic stop_run();
    en      = 1'b0;
    running = 1'b0;
  endtask

  task automatic idle_load(input logic [7:0] v);
    div_val  = v;
    div_load = 1'b1;
    run(1);
    div_load = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    en       = 1'b0;
    div_val  = 8'd0;
    div_load = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_sys_rst_n", sys_rst_n, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_div_clk", div_clk, 1'b0);

    // Release; div_val=4 loaded while still in HOLD
    rst_n = 1'b1;
    hold_seq(1'b1);

    // div=4: tick every 5th cycle, div_clk period 10, 20 periods
    start_run(5);
    run(100);

    // Drop en mid-period: tick stops and div_clk freezes
    run(2);
    stop_run();
    run(12);

    // Re-raise: first tick after active_div+1 cycles
    start_run(5);
    run(12);

    // div=0: tick every cycle, div_clk toggles every cycle
    stop_run();
    run(1);
    idle_load(8'd0);
    start_run(1);
    run(10);

    // div=9, then div_val=2 loaded mid-period
    stop_run();
    run(1);
    idle_load(8'd9);
    start_run(10);
    run(13);
    div_val    = 8'd2;
    div_load   = 1'b1;
    new_period = 3;
    run(1);
    div_load   = 1'b0;
    run(20);

    // Back to a 10-cycle period via a mid-period load
    run_until_tick();
    run(1);
    div_val    = 8'd9;
    div_load   = 1'b1;
    new_period = 10;
    run(1);
    div_load   = 1'b0;
    run_until_tick();
    run_until_tick();

    // Load coincident with the tick cycle: governs the very next period
    div_val    = 8'd2;
    div_load   = 1'b1;
    cur_period = 3;
    new_period = 3;
    next_tick  = cyc + 3;
    run(1);
    div_load   = 1'b0;
    run(12);

    // All-ones divide value: 256-cycle period, no wrap
    stop_run();
    run(1);
    idle_load(8'hFF);
    start_run(256);
    run(520);

    // Half-cycle reset mid-RUN: outputs drop at once
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("async_tick", tick, 1'b0);
    chk("async_div_clk", div_clk, 1'b0);
    chk("async_ready", ready, 1'b0);
    chk("async_sys_rst_n", sys_rst_n, 1'b0);
    #3 rst_n = 1'b1;
    running   = 1'b0;
    prev_tick = 1'b0;
    exp_dc    = 1'b0;

    // Full hold sequence repeats
    hold_seq(1'b0);

    // active_div cleared by reset: tick every cycle
    start_run(1);
    run(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
